gb_instr_sequencer: RTL and testbench

- Synthesizable, parametrised opcode stimulus engine. It drives the `instruction`/`valid` inputs of `gbprocessor` in place of a free-running increment loop.
- Supports a configurable range (`first..last`), stride, pass count and two modes: linear sweep or Galois-LFSR pseudo-random.
- Uses a valid/ready handshake, so a stalling consumer never loses an opcode.
- Sits between the test top and the DUT's interface. It can also live in an on-chip self-test wrapper.

---
 rtl/gb_seq_pkg.sv | 8 +
 rtl/gb_lfsr.sv | 32 +++
 rtl/gb_instr_sequencer.sv | 147 ++++++++++++++
 tb/tb_gb_instr_sequencer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/gb_seq_pkg.sv
// Shared types and default constants for the opcode stimulus sequencer.
package gb_seq_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FINISH} seq_state_t;
  typedef enum logic {SWEEP = 1'b0, LFSR = 1'b1} seq_mode_t;

  localparam int              GB_INSTR_WIDTH = 8;
  localparam logic [7:0]      GB_LFSR_TAPS   = 8'hB8;
endpackage

// File: rtl/gb_lfsr.sv
// Galois LFSR with synchronous load (zero seed becomes 1) and advance.
// Load wins over advance; state is visible on the cycle after the edge.
module gb_lfsr #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'hB8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] seed_i,
  input  logic             advance_i,
  output logic [WIDTH-1:0] state_o
);
  logic [WIDTH-1:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (load_i) begin
      // An all-zero state would lock up, so a zero seed is promoted to 1.
      state_d = (seed_i == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : seed_i;
    end else if (advance_i) begin
      state_d = (state_q >> 1) ^ (state_q[0] ? TAPS : '0);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= '0;
    else       state_q <= state_d;
  end

  assign state_o = state_q;
endmodule

// File: rtl/gb_instr_sequencer.sv
// Opcode stimulus engine: linear sweep or LFSR over a captured range, repeated passes.
// Offers one opcode per cycle on valid/ready; a stalled consumer holds the current opcode.
module gb_instr_sequencer
  import gb_seq_pkg::*;
#(
  parameter int                     INSTR_WIDTH  = GB_INSTR_WIDTH,
  parameter int                     REPEAT_WIDTH = 8,
  parameter int                     COUNT_WIDTH  = 16,
  parameter logic [INSTR_WIDTH-1:0] LFSR_TAPS    = GB_LFSR_TAPS
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    mode,
  input  logic [INSTR_WIDTH-1:0]  first,
  input  logic [INSTR_WIDTH-1:0]  last,
  input  logic [INSTR_WIDTH-1:0]  step,
  input  logic [REPEAT_WIDTH-1:0] repeats,
  input  logic                    ready,
  output logic [INSTR_WIDTH-1:0]  instruction,
  output logic                    valid,
  output logic                    busy,
  output logic                    done,
  output logic [COUNT_WIDTH-1:0]  count
);
  localparam int W = INSTR_WIDTH;

  seq_state_t        state_q, state_d;
  seq_mode_t         mode_q, mode_d;
  logic [W-1:0]      first_q, first_d;
  logic [W-1:0]      step_q, step_d;
  logic [W-1:0]      sweep_q, sweep_d;
  logic [REPEAT_WIDTH-1:0] pass_q, pass_d;
  logic [W:0]        n_q, n_d;
  logic [W:0]        left_q, left_d;
  logic [COUNT_WIDTH-1:0]  count_q, count_d;

  logic [W-1:0]      step_eff;
  logic [W-1:0]      span;
  logic [W:0]        n_start;
  logic              lfsr_load, lfsr_adv;
  logic [W-1:0]      lfsr_seed, lfsr_state;

  // Per-pass issue count needs W+1 bits: a full-range sweep issues 2^W opcodes.
  assign step_eff = (step == '0) ? {{(W-1){1'b0}}, 1'b1} : step;
  assign span     = last - first;
  assign n_start  = (W+1)'(span / step_eff) + (W+1)'(1);

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    first_d   = first_q;
    step_d    = step_q;
    sweep_d   = sweep_q;
    pass_d    = pass_q;
    n_d       = n_q;
    left_d    = left_q;
    count_d   = count_q;
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;
    lfsr_seed = first_q;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d   = RUN;
          mode_d    = seq_mode_t'(mode);
          first_d   = first;
          step_d    = step_eff;
          pass_d    = repeats;
          n_d       = n_start;
          left_d    = n_start;
          sweep_d   = first;
          count_d   = '0;
          lfsr_load = 1'b1;
          lfsr_seed = first;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (ready) begin
          if (count_q != '1) count_d = count_q + COUNT_WIDTH'(1);
          if (left_q == (W+1)'(1)) begin
            if (pass_q == '0) begin
              state_d = FINISH;
            end else begin
              // Reload in the same edge so the next pass follows without a bubble.
              pass_d    = pass_q - REPEAT_WIDTH'(1);
              left_d    = n_q;
              sweep_d   = first_q;
              lfsr_load = 1'b1;
            end
          end else begin
            left_d   = left_q - (W+1)'(1);
            sweep_d  = sweep_q + step_q;
            lfsr_adv = 1'b1;
          end
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      mode_q  <= SWEEP;
      first_q <= '0;
      step_q  <= '0;
      sweep_q <= '0;
      pass_q  <= '0;
      n_q     <= '0;
      left_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      first_q <= first_d;
      step_q  <= step_d;
      sweep_q <= sweep_d;
      pass_q  <= pass_d;
      n_q     <= n_d;
      left_q  <= left_d;
      count_q <= count_d;
    end
  end

  gb_lfsr #(
    .WIDTH (W),
    .TAPS  (LFSR_TAPS)
  ) u_lfsr (
    .clk_i     (clock),
    .rst_i     (reset),
    .load_i    (lfsr_load),
    .seed_i    (lfsr_seed),
    .advance_i (lfsr_adv),
    .state_o   (lfsr_state)
  );

  assign instruction = (mode_q == LFSR) ? lfsr_state : sweep_q;
  assign valid       = (state_q == RUN);
  assign busy        = (state_q == RUN);
  assign done        = (state_q == FINISH);
  assign count       = count_q;
endmodule

// File: tb/tb_gb_instr_sequencer.sv
// Directed bench for gb_instr_sequencer: sweep, wrap, stride, backpressure, LFSR, abort, reset.
module tb_gb_instr_sequencer;
  logic        clock, reset, start, abort, mode, ready;
  logic [7:0]  first, last, step, repeats;
  logic [7:0]  instruction;
  logic        valid, busy, done;
  logic [15:0] count;

  int errors = 0;
  int checks = 0;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  logic [7:0] lfsr5 [5] = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17};

  gb_instr_sequencer dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .mode        (mode),
    .first       (first),
    .last        (last),
    .step        (step),
    .repeats     (repeats),
    .ready       (ready),
    .instruction (instruction),
    .valid       (valid),
    .busy        (busy),
    .done        (done),
    .count       (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_seq(input string tag);
    chk({tag, "_len"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      chk(tag, 32'(got[i]), 32'(exp_q[i]));
  endtask

  // Call at a negedge; leaves the bench at the negedge where the first opcode is offered.
  task automatic do_start(input logic m, input logic [7:0] f, input logic [7:0] l,
                          input logic [7:0] s, input logic [7:0] r);
    chk("idle_valid", 32'(valid), 32'd0);
    mode = m; first = f; last = l; step = s; repeats = r; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("start_latency", 32'(valid), 32'd1);
  endtask

  // Drives ready from stall mask, optionally pulses start mid-run, records transfers until done.
  task automatic collect(input logic [31:0] stall, input int start_k, input int maxcyc);
    int   last_tx, done_at;
    logic held_vld;
    logic [7:0] held_val;
    got.delete();
    last_tx = -10; done_at = -1; held_vld = 1'b0; held_val = '0;
    for (int k = 0; k < maxcyc; k++) begin
      ready = (k < 32) ? !stall[k] : 1'b1;
      start = (k == start_k);
      if (k == start_k) first = 8'h80;
      if (held_vld) chk("hold", {23'd0, valid, instruction}, {23'd0, 1'b1, held_val});
      if (done) begin
        done_at = k;
        chk("finish_valid", 32'(valid), 32'd0);
        chk("finish_busy", 32'(busy), 32'd0);
        break;
      end
      if (valid && ready) begin
        got.push_back(instruction);
        last_tx = k;
      end
      held_vld = valid && !ready;
      held_val = instruction;
      @(negedge clock);
    end
    start = 1'b0;
    ready = 1'b1;
    chk("done_seen", 32'(done_at >= 0), 32'd1);
    chk("done_timing", 32'(done_at), 32'(last_tx + 1));
    @(negedge clock);
    chk("done_pulse", 32'(done), 32'd0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0; mode = 1'b0; ready = 1'b1;
    first = '0; last = '0; step = '0; repeats = '0;
    #1 reset = 1'b1;
    #2;
    chk("rst_instr", 32'(instruction), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    @(negedge clock); @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Full-range sweep
    do_start(1'b0, 8'h00, 8'hFF, 8'd1, 8'd0);
    collect(32'd0, -1, 300);
    exp_q.delete();
    for (int i = 0; i < 256; i++) exp_q.push_back(8'(i));
    chk_seq("full_sweep");
    chk("full_count", 32'(count), 32'd256);

    // Wrap-around range
    do_start(1'b0, 8'hFE, 8'h02, 8'd1, 8'd0);
    collect(32'd0, -1, 40);
    exp_q = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02};
    chk_seq("wrap");
    chk("wrap_count", 32'(count), 32'd5);

    // Stride that overshoots last
    do_start(1'b0, 8'h10, 8'h20, 8'd6, 8'd0);
    collect(32'd0, -1, 40);
    exp_q = '{8'h10, 8'h16, 8'h1C};
    chk_seq("stride6");
    chk("stride6_count", 32'(count), 32'd3);

    // Step 0 behaves as 1, single-element range
    do_start(1'b0, 8'h40, 8'h40, 8'd0, 8'd0);
    collect(32'd0, -1, 40);
    exp_q = '{8'h40};
    chk_seq("step0");
    chk("step0_count", 32'(count), 32'd1);

    // Backpressure: stall three cycles while 0x01 is offered
    do_start(1'b0, 8'h00, 8'h03, 8'd1, 8'd0);
    collect(32'b1110, -1, 40);
    exp_q = '{8'h00, 8'h01, 8'h02, 8'h03};
    chk_seq("bp");
    chk("bp_count", 32'(count), 32'd4);
    repeat (3) @(negedge clock);
    chk("count_hold", 32'(count), 32'd4);

    // LFSR with one repeat
    do_start(1'b1, 8'h01, 8'h05, 8'd1, 8'd1);
    collect(32'd0, -1, 40);
    exp_q.delete();
    for (int p = 0; p < 2; p++) for (int i = 0; i < 5; i++) exp_q.push_back(lfsr5[i]);
    chk_seq("lfsr_rep");
    chk("lfsr_rep_count", 32'(count), 32'd10);

    // Zero seed behaves as seed 1
    do_start(1'b1, 8'h00, 8'h04, 8'd1, 8'd0);
    collect(32'd0, -1, 40);
    exp_q.delete();
    for (int i = 0; i < 5; i++) exp_q.push_back(lfsr5[i]);
    chk_seq("lfsr_seed0");

    // Abort after five transfers
    ready = 1'b1;
    do_start(1'b0, 8'h00, 8'hFF, 8'd1, 8'd0);
    for (int i = 0; i < 5; i++) begin
      chk("abort_pre", 32'(instruction), 32'(i));
      @(negedge clock);
    end
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    chk("abort_valid", 32'(valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_count", 32'(count), 32'd5);
    @(negedge clock);
    chk("abort_no_done", 32'(done), 32'd0);

    // Start together with abort in IDLE does nothing
    start = 1'b1; abort = 1'b1;
    @(negedge clock);
    start = 1'b0; abort = 1'b0;
    chk("sa_valid", 32'(valid), 32'd0);
    @(negedge clock);
    chk("sa_busy", 32'(busy), 32'd0);
    chk("sa_count", 32'(count), 32'd5);

    // Asynchronous reset between edges mid-run
    do_start(1'b0, 8'h00, 8'hFF, 8'd1, 8'd0);
    repeat (3) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("mrst_instr", 32'(instruction), 32'd0);
    chk("mrst_valid", 32'(valid), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_count", 32'(count), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("mrst_no_done", 32'(done), 32'd0);

    // Restart; start pulse and first change during RUN are ignored
    do_start(1'b0, 8'h30, 8'h33, 8'd1, 8'd0);
    collect(32'd0, 1, 40);
    exp_q = '{8'h30, 8'h31, 8'h32, 8'h33};
    chk_seq("restart");
    chk("restart_count", 32'(count), 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
